// File: rtl/cm_pkg.sv
// cm_pkg: widths, byte encodings, FSM/error codes and debug palette for the config manager
package cm_pkg;
  localparam int UART_W = 8;
  localparam int ADDR_W = 2;
  localparam int COLOUR_W = 6;
  localparam int STATUS_W = 2;
  localparam int NOTIF_W = 2;
  localparam int ERR_W = 2;
  localparam int VGA_NOTIF_W = 2;
  localparam logic [3:0] HDR_OPCODE = 4'b1010;
  typedef enum logic [1:0] {BT_HDR = 2'b00, BT_DATA = 2'b01} byte_t;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_DATA = 2'd1, WAIT_ACK = 2'd2} state_t;
  localparam logic [1:0] ERR_BAD_BYTE = 2'b01;
  localparam logic [1:0] ERR_UNEXPECTED = 2'b10;
  localparam logic [1:0] ERR_BUSY = 2'b11;
  localparam logic [5:0] DBG_LU = 6'b110000;
  localparam logic [5:0] DBG_RU = 6'b001100;
  localparam logic [5:0] DBG_LD = 6'b000011;
  localparam logic [5:0] DBG_RD = 6'b111111;
  function automatic logic [5:0] dbg_colour(input logic [1:0] idx);
    return idx == 2'd0 ? DBG_LU : idx == 2'd1 ? DBG_RU : idx == 2'd2 ? DBG_LD : DBG_RD;
  endfunction
endpackage

// File: rtl/cm_config_manager_sync_edge.sv
// cm_sync_edge: registers HSync/VSync and reports their rising edges as a one-cycle event
module cm_sync_edge (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hsync,
  input  logic       vsync,
  output logic [1:0] events,
  output logic       events_valid
);
  logic hs_q, vs_q, hs_rise, vs_rise;
  assign hs_rise = hsync & ~hs_q;
  assign vs_rise = vsync & ~vs_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q <= 1'b0;
      vs_q <= 1'b0;
      events <= 2'b00;
      events_valid <= 1'b0;
    end else begin
      hs_q <= hsync;
      vs_q <= vsync;
      events <= {hs_rise, vs_rise};
      events_valid <= hs_rise | vs_rise;
    end
  end
endmodule

// File: rtl/cm_config_manager.sv
// cm_config_manager: parses two-byte quadrant colour commands, forwards them over valid/ready,
// keeps the quadrant palette that drives Data_VGA, and reports status, errors and sync events
module cm_config_manager
  import cm_pkg::*;
#(
  parameter int UART_DATA_WIDTH = UART_W,
  parameter int c_addr_WIDTH = ADDR_W,
  parameter int c_data_WIDTH = COLOUR_W,
  parameter int DATA_WIDTH = COLOUR_W,
  parameter int CONFIG_STATUS_WIDTH = STATUS_W,
  parameter int CONFIG_NOTIFICATION_WIDTH = NOTIF_W,
  parameter int CONFIG_ERROR_WIDTH = ERR_W,
  parameter int VGA_NOTIFICATION_WIDTH = VGA_NOTIF_W
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 Empty,
  input  logic [UART_DATA_WIDTH-1:0]           RXD_Data,
  input  logic                                 c_ready,
  input  logic                                 Vertical_Split,
  input  logic                                 Horizontal_Split,
  input  logic                                 VGA_debug,
  input  logic                                 HSync,
  input  logic                                 VSync,
  output logic [c_addr_WIDTH-1:0]              c_addr,
  output logic [c_data_WIDTH-1:0]              c_data,
  output logic                                 c_valid,
  output logic [CONFIG_STATUS_WIDTH-1:0]       Config_Status,
  output logic [CONFIG_NOTIFICATION_WIDTH-1:0] Config_Notification,
  output logic                                 Config_Notification_Valid,
  output logic [CONFIG_ERROR_WIDTH-1:0]        Config_Error,
  output logic                                 Error_Valid,
  output logic [VGA_NOTIFICATION_WIDTH-1:0]    VGA_Notification,
  output logic                                 VGA_Notification_Valid,
  output logic [DATA_WIDTH-1:0]                Data_VGA
);
  state_t state;
  logic [c_addr_WIDTH-1:0] quad;
  logic [c_data_WIDTH-1:0] palette [4];
  logic [1:0] idx;
  logic hdr_ok, is_data, commit;
  assign idx = {Horizontal_Split, Vertical_Split};
  assign hdr_ok = RXD_Data[7:6] == BT_HDR && RXD_Data[3:0] == HDR_OPCODE;
  assign is_data = RXD_Data[7:6] == BT_DATA;
  assign commit = state == WAIT_ACK && c_valid && c_ready;
  assign Config_Status = state;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      quad <= '0;
      c_addr <= '0;
      c_data <= '0;
      c_valid <= 1'b0;
      Config_Notification <= '0;
      Config_Notification_Valid <= 1'b0;
      Config_Error <= '0;
      Error_Valid <= 1'b0;
      Data_VGA <= '0;
      palette <= '{default: '0};
    end else begin
      Config_Notification_Valid <= 1'b0;
      Error_Valid <= 1'b0;
      // pixel uses the palette as it stood before any write committing this edge
      Data_VGA <= VGA_debug ? dbg_colour(idx) : palette[idx];
      if (commit) begin
        palette[c_addr] <= c_data;
        c_valid <= 1'b0;
        Config_Notification <= c_addr;
        Config_Notification_Valid <= 1'b1;
        state <= IDLE;
      end
      if (!Empty) begin
        if (state == IDLE) begin
          if (hdr_ok) begin
            quad <= RXD_Data[5:4];
            state <= WAIT_DATA;
          end else begin
            Config_Error <= ERR_BAD_BYTE;
            Error_Valid <= 1'b1;
          end
        end else if (state == WAIT_DATA) begin
          if (is_data) begin
            c_addr <= quad;
            c_data <= RXD_Data[5:0];
            c_valid <= 1'b1;
            state <= WAIT_ACK;
          end else begin
            Config_Error <= ERR_UNEXPECTED;
            Error_Valid <= 1'b1;
            state <= IDLE;
          end
        end else begin
          Config_Error <= ERR_BUSY;
          Error_Valid <= 1'b1;
        end
      end
    end
  end
  cm_sync_edge u_sync_edge (
    .clk         (clk),
    .rst_n       (rst_n),
    .hsync       (HSync),
    .vsync       (VSync),
    .events      (VGA_Notification),
    .events_valid(VGA_Notification_Valid)
  );
endmodule

// File: tb/tb_cm_config_manager.sv
// tb_cm_config_manager: randomized + directed stimulus against a command-level reference model
module tb_cm_config_manager;
  logic clk = 0, rst_n = 0, Empty = 1, c_ready = 0;
  logic [7:0] RXD_Data = 0;
  logic Vertical_Split = 0, Horizontal_Split = 0, VGA_debug = 0, HSync = 0, VSync = 0;
  logic [1:0] c_addr, Config_Status, Config_Notification, Config_Error, VGA_Notification;
  logic [5:0] c_data, Data_VGA;
  logic c_valid, Config_Notification_Valid, Error_Valid, VGA_Notification_Valid;
  always #5 clk = ~clk;
  cm_config_manager dut (
    .clk(clk), .rst_n(rst_n), .Empty(Empty), .RXD_Data(RXD_Data), .c_ready(c_ready),
    .Vertical_Split(Vertical_Split), .Horizontal_Split(Horizontal_Split), .VGA_debug(VGA_debug),
    .HSync(HSync), .VSync(VSync), .c_addr(c_addr), .c_data(c_data), .c_valid(c_valid),
    .Config_Status(Config_Status), .Config_Notification(Config_Notification),
    .Config_Notification_Valid(Config_Notification_Valid), .Config_Error(Config_Error),
    .Error_Valid(Error_Valid), .VGA_Notification(VGA_Notification),
    .VGA_Notification_Valid(VGA_Notification_Valid), .Data_VGA(Data_VGA)
  );
  typedef struct {int st; bit cv; int ca; int cd; int pix; bit ev; bit nv; bit vv;} exp_t;
  exp_t cyc_q[$];
  int err_q[$], notif_q[$], vga_q[$];
  int n_pass = 0, n_total = 0;
  // reference model: a palette, an optional pending header and an optional outstanding write
  int pal[4];
  int dbg_pal[4] = '{'h30, 'h0C, 'h03, 'h3F};
  int hdr_q = -1, wa = 0, wd = 0;
  bit busy = 0, prev_h = 0, prev_v = 0;
  bit n_h = 0, n_v = 0, n_hs = 0, n_vs = 0, n_dbg = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic step(input bit bv, input logic [7:0] b, input bit rdy);
    exp_t e;
    bit was_busy, rh, rv;
    int idx;
    @(negedge clk);
    Empty = !bv;
    RXD_Data = bv ? b : 8'($urandom);
    c_ready = rdy;
    Horizontal_Split = n_h; Vertical_Split = n_v; HSync = n_hs; VSync = n_vs; VGA_debug = n_dbg;
    idx = 2 * int'(n_h) + int'(n_v);
    e = '{default: 0};
    e.pix = n_dbg ? dbg_pal[idx] : pal[idx];
    was_busy = busy;
    if (busy && rdy) begin
      pal[wa] = wd; busy = 0; notif_q.push_back(wa); e.nv = 1;
    end
    if (bv) begin
      e.ev = 1;
      if (was_busy) err_q.push_back(3);
      else if (hdr_q >= 0) begin
        if (b[7:6] == 2'b01) begin busy = 1; wa = hdr_q; wd = int'(b[5:0]); e.ev = 0; end
        else err_q.push_back(2);
        hdr_q = -1;
      end else if (b[7:6] == 2'b00 && b[3:0] == 4'hA) begin hdr_q = int'(b[5:4]); e.ev = 0; end
      else err_q.push_back(1);
    end
    rh = n_hs && !prev_h; rv = n_vs && !prev_v;
    prev_h = n_hs; prev_v = n_vs;
    if (rh || rv) begin vga_q.push_back(2 * int'(rh) + int'(rv)); e.vv = 1; end
    e.st = busy ? 2 : hdr_q >= 0 ? 1 : 0;
    e.cv = busy; e.ca = wa; e.cd = wd;
    cyc_q.push_back(e);
  endtask
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 0;
    cyc_q.delete(); err_q.delete(); notif_q.delete(); vga_q.delete();
    pal = '{0, 0, 0, 0}; hdr_q = -1; busy = 0; prev_h = 0; prev_v = 0;
    n_h = 0; n_v = 0; n_hs = 0; n_vs = 0; n_dbg = 0;
    Empty = 1; c_ready = 0; Horizontal_Split = 0; Vertical_Split = 0;
    HSync = 0; VSync = 0; VGA_debug = 0;
    #1;
    chk("rst_c_valid", c_valid, 0);
    chk("rst_c_addr", c_addr, 0);
    chk("rst_c_data", c_data, 0);
    chk("rst_status", Config_Status, 0);
    chk("rst_notif", {Config_Notification, Config_Notification_Valid}, 0);
    chk("rst_err", {Config_Error, Error_Valid}, 0);
    chk("rst_vga_notif", {VGA_Notification, VGA_Notification_Valid}, 0);
    chk("rst_data_vga", Data_VGA, 0);
    @(negedge clk);
    rst_n = 1;
  endtask
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && cyc_q.size() > 0) begin
        e = cyc_q.pop_front();
        chk("status", Config_Status, e.st);
        chk("c_valid", c_valid, e.cv);
        if (e.cv) begin
          chk("c_addr", c_addr, e.ca);
          chk("c_data", c_data, e.cd);
        end
        chk("data_vga", Data_VGA, e.pix);
        chk("err_valid", Error_Valid, e.ev);
        chk("notif_valid", Config_Notification_Valid, e.nv);
        chk("vga_valid", VGA_Notification_Valid, e.vv);
        if (Error_Valid && err_q.size() > 0) chk("err_code", Config_Error, err_q.pop_front());
        if (Config_Notification_Valid && notif_q.size() > 0)
          chk("notif_code", Config_Notification, notif_q.pop_front());
        if (VGA_Notification_Valid && vga_q.size() > 0)
          chk("vga_code", VGA_Notification, vga_q.pop_front());
      end
    end
  end
  initial begin
    do_reset();
    step(1, 8'h0A, 0); step(1, 8'h5A, 0);
    repeat (5) step(0, 0, 0);
    step(0, 0, 1); step(0, 0, 0); step(0, 0, 0);
    step(1, 8'h1A, 1); step(1, 8'h5F, 1); step(0, 0, 1);
    step(1, 8'h3A, 1); step(1, 8'h50, 1); step(0, 0, 1);
    step(1, 8'h2A, 1); step(1, 8'h00, 1);
    n_h = 1; n_v = 1; repeat (2) step(0, 0, 0);
    n_v = 0; repeat (2) step(0, 0, 0);
    n_h = 0; n_v = 1; repeat (2) step(0, 0, 0);
    step(1, 8'h0F, 0); step(1, 8'hC0, 0);
    step(1, 8'h0A, 0); step(1, 8'h45, 0); step(1, 8'h1A, 0);
    step(0, 0, 0); step(0, 0, 1); step(0, 0, 0);
    n_dbg = 1;
    for (int i = 0; i < 4; i++) begin
      n_h = 1'(i >> 1); n_v = 1'(i);
      repeat (2) step(0, 0, 0);
    end
    n_dbg = 0;
    n_hs = 1; step(0, 0, 0); n_hs = 0; step(0, 0, 0);
    n_vs = 1; step(0, 0, 0); n_vs = 0; step(0, 0, 0);
    n_hs = 1; n_vs = 1; step(0, 0, 0); step(0, 0, 0);
    n_hs = 0; n_vs = 0; step(0, 0, 0);
    for (int i = 0; i < 800; i++) begin
      int r;
      logic [7:0] b;
      r = $urandom_range(0, 9);
      b = r < 4 ? {2'b00, 2'($urandom), 4'hA} : r < 8 ? {2'b01, 6'($urandom)} : 8'($urandom);
      n_h = 1'($urandom); n_v = 1'($urandom);
      n_hs = 1'($urandom); n_vs = 1'($urandom);
      n_dbg = $urandom_range(0, 7) == 0;
      step($urandom_range(0, 2) != 0, b, $urandom_range(0, 2) == 0);
    end
    n_h = 0; n_v = 0; n_hs = 0; n_vs = 0; n_dbg = 0;
    step(0, 0, 1); step(0, 0, 0);
    step(1, 8'h0A, 1); step(1, 8'h7F, 1); step(0, 0, 1); step(0, 0, 0); step(0, 0, 0);
    step(1, 8'h0A, 0); step(1, 8'h55, 0); step(0, 0, 0);
    do_reset();
    repeat (3) step(0, 0, 1);
    @(posedge clk);
    #3;
    chk("cyc_q_drained", cyc_q.size(), 0);
    chk("err_q_drained", err_q.size(), 0);
    chk("notif_q_drained", notif_q.size(), 0);
    chk("vga_q_drained", vga_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
